set_assoc_cache: RTL

//  N-way set-associative, write-through, read-allocate data cache between the core's

---
 rtl/cache_pkg.sv | 42 ++++
 rtl/cache_way.sv | 58 +++++
 rtl/set_assoc_cache.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/cache_pkg.sv
// rtl/cache_pkg.sv - shared FSM states and address/byte helpers for set_assoc_cache
package cache_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_MISS = 2'd1,
    WR_THRU = 2'd2
  } cache_state_e;

  // Helpers work on the widest supported vectors; callers cast to their own widths.
  localparam int MAX_ADDR_WIDTH = 64;
  localparam int MAX_DATA_WIDTH = 256;
  localparam int MAX_BE_WIDTH   = MAX_DATA_WIDTH / 8;

  function automatic logic [MAX_ADDR_WIDTH-1:0] addr_index(
    input logic [MAX_ADDR_WIDTH-1:0] addr,
    input int                        set_w
  );
    return (addr >> 2) & ((64'd1 << set_w) - 64'd1);
  endfunction

  function automatic logic [MAX_ADDR_WIDTH-1:0] addr_tag(
    input logic [MAX_ADDR_WIDTH-1:0] addr,
    input int                        set_w
  );
    return addr >> (set_w + 2);
  endfunction

  function automatic logic [MAX_DATA_WIDTH-1:0] merge_bytes(
    input logic [MAX_DATA_WIDTH-1:0] old_data,
    input logic [MAX_DATA_WIDTH-1:0] new_data,
    input logic [MAX_BE_WIDTH-1:0]   be
  );
    logic [MAX_DATA_WIDTH-1:0] merged;
    merged = old_data;
    for (int b = 0; b < MAX_BE_WIDTH; b++) begin
      if (be[b]) merged[b*8 +: 8] = new_data[b*8 +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/cache_way.sv
// rtl/cache_way.sv - one cache way: valid/tag/data arrays with read, fill and byte-write ports
module cache_way
  import cache_pkg::*;
#(
  parameter int TAG_WIDTH         = 12,
  parameter int DATA_WIDTH        = 32,
  parameter int SET_ADDRESS_WIDTH = 3
) (
  input  logic                         CLK,
  input  logic                         RST_N,
  input  logic                         flush,
  input  logic [SET_ADDRESS_WIDTH-1:0] index,
  output logic                         valid,
  output logic [TAG_WIDTH-1:0]         tag,
  output logic [DATA_WIDTH-1:0]        data,
  input  logic                         fill_en,
  input  logic [TAG_WIDTH-1:0]         fill_tag,
  input  logic [DATA_WIDTH-1:0]        fill_data,
  input  logic                         wr_en,
  input  logic [DATA_WIDTH/8-1:0]      wr_be,
  input  logic [DATA_WIDTH-1:0]        wr_data
);

  localparam int SETS = 1 << SET_ADDRESS_WIDTH;

  logic [SETS-1:0]       valid_q;
  logic [TAG_WIDTH-1:0]  tag_q  [SETS];
  logic [DATA_WIDTH-1:0] data_q [SETS];
  logic [DATA_WIDTH-1:0] merged;

  assign valid  = valid_q[index];
  assign tag    = tag_q[index];
  assign data   = data_q[index];
  assign merged = DATA_WIDTH'(merge_bytes(MAX_DATA_WIDTH'(data_q[index]),
                                          MAX_DATA_WIDTH'(wr_data),
                                          MAX_BE_WIDTH'(wr_be)));

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      valid_q <= '0;
    end else if (flush) begin
      valid_q <= '0;
    end else if (fill_en) begin
      valid_q[index] <= 1'b1;
    end
  end

  // Tag/data storage needs no reset; valid_q gates every use of it.
  always_ff @(posedge CLK) begin
    if (fill_en) begin
      tag_q[index]  <= fill_tag;
      data_q[index] <= fill_data;
    end else if (wr_en) begin
      data_q[index] <= merged;
    end
  end

endmodule

// File: rtl/set_assoc_cache.sv
// rtl/set_assoc_cache.sv - N-way write-through, read-allocate data cache with miss FSM
module set_assoc_cache
  import cache_pkg::*;
#(
  parameter  int ADDRESS_WIDTH     = 17,
  parameter  int DATA_WIDTH        = 32,
  parameter  int SET_ADDRESS_WIDTH = 3,
  parameter  int WAYS              = 2,
  localparam int BE_WIDTH          = DATA_WIDTH / 8,
  localparam int TAG_WIDTH         = ADDRESS_WIDTH - SET_ADDRESS_WIDTH - 2
) (
  input  logic                     CLK,
  input  logic                     RST_N,
  input  logic                     req_i,
  input  logic [BE_WIDTH-1:0]      we_i,
  input  logic [ADDRESS_WIDTH-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0]    wdata_i,
  input  logic                     flush_i,
  output logic [DATA_WIDTH-1:0]    rdata_o,
  output logic                     ready_o,
  output logic                     hit_o,
  output logic                     mem_req_o,
  output logic [BE_WIDTH-1:0]      mem_we_o,
  output logic [ADDRESS_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0]    mem_wdata_o,
  input  logic [DATA_WIDTH-1:0]    mem_rdata_i,
  input  logic                     mem_ack_i
);

  localparam int SETS = 1 << SET_ADDRESS_WIDTH;
  localparam int WIDX = (WAYS > 1) ? $clog2(WAYS) : 1;

  cache_state_e state_q, state_d;

  logic [SET_ADDRESS_WIDTH-1:0] index;
  logic [TAG_WIDTH-1:0]         tag;
  logic [WAYS-1:0]              way_valid;
  logic [TAG_WIDTH-1:0]         way_tag  [WAYS];
  logic [DATA_WIDTH-1:0]        way_data [WAYS];
  logic [WAYS-1:0]              way_hit;
  logic [WAYS-1:0]              fill_sel;
  logic [WAYS-1:0]              wr_sel;
  logic                         hit;
  logic [DATA_WIDTH-1:0]        hit_data;
  logic [WIDX-1:0]              rr_q [SETS];
  logic [WIDX-1:0]              victim;
  logic                         victim_found;
  logic                         refill;
  logic                         flush_en;

  assign index = SET_ADDRESS_WIDTH'(addr_index(MAX_ADDR_WIDTH'(addr_i), SET_ADDRESS_WIDTH));
  assign tag   = TAG_WIDTH'(addr_tag(MAX_ADDR_WIDTH'(addr_i), SET_ADDRESS_WIDTH));

  assign mem_addr_o  = addr_i;
  assign mem_wdata_o = wdata_i;
  assign refill      = (state_q == RD_MISS) && mem_ack_i;
  assign flush_en    = (state_q == IDLE) && flush_i;

  // At most one way can match, so OR-ing the matching data is a valid mux.
  always_comb begin
    hit_data = '0;
    for (int w = 0; w < WAYS; w++) begin
      way_hit[w] = way_valid[w] && (way_tag[w] == tag);
      if (way_hit[w]) hit_data = hit_data | way_data[w];
    end
    hit = |way_hit;
  end

  always_comb begin
    victim       = rr_q[index];
    victim_found = 1'b0;
    for (int w = 0; w < WAYS; w++) begin
      if (!victim_found && !way_valid[w]) begin
        victim       = WIDX'(w);
        victim_found = 1'b1;
      end
    end
  end

  always_comb begin
    for (int w = 0; w < WAYS; w++) begin
      fill_sel[w] = refill && (victim == WIDX'(w));
      wr_sel[w]   = (state_q == WR_THRU) && mem_ack_i && way_hit[w];
    end
  end

  // Pointer advances only when a valid line is evicted, so filling empty ways keeps it put.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int s = 0; s < SETS; s++) rr_q[s] <= '0;
    end else if (refill && !victim_found) begin
      rr_q[index] <= (rr_q[index] == WIDX'(WAYS - 1)) ? '0 : rr_q[index] + WIDX'(1);
    end
  end

  for (genvar w = 0; w < WAYS; w++) begin : g_way
    cache_way #(
      .TAG_WIDTH        (TAG_WIDTH),
      .DATA_WIDTH       (DATA_WIDTH),
      .SET_ADDRESS_WIDTH(SET_ADDRESS_WIDTH)
    ) u_way (
      .CLK      (CLK),
      .RST_N    (RST_N),
      .flush    (flush_en),
      .index    (index),
      .valid    (way_valid[w]),
      .tag      (way_tag[w]),
      .data     (way_data[w]),
      .fill_en  (fill_sel[w]),
      .fill_tag (tag),
      .fill_data(mem_rdata_i),
      .wr_en    (wr_sel[w]),
      .wr_be    (we_i),
      .wr_data  (wdata_i)
    );
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    ready_o   = 1'b0;
    rdata_o   = '0;
    hit_o     = 1'b0;
    mem_req_o = 1'b0;
    mem_we_o  = '0;
    case (state_q)
      IDLE: begin
        hit_o = req_i && hit;
        if (!flush_i && req_i) begin
          if (we_i != '0) begin
            state_d = WR_THRU;
          end else if (hit) begin
            ready_o = 1'b1;
            rdata_o = hit_data;
          end else begin
            state_d = RD_MISS;
          end
        end
      end
      RD_MISS: begin
        mem_req_o = 1'b1;
        if (mem_ack_i) begin
          ready_o = 1'b1;
          rdata_o = mem_rdata_i;
          state_d = IDLE;
        end
      end
      WR_THRU: begin
        mem_req_o = 1'b1;
        mem_we_o  = we_i;
        if (mem_ack_i) begin
          ready_o = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule
